mod_trig_scheduler: RTL and testbench



---
 rtl/fog_sched_pkg.sv | 11 +
 rtl/mod_trig_scheduler_cfg_validate.sv | 23 ++
 rtl/mod_trig_scheduler.sv | 126 ++++++++++++
 tb/tb_mod_trig_scheduler.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fog_sched_pkg.sv
// fog_sched_pkg: state encoding and shared constants for the modulation trigger scheduler
package fog_sched_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, RUN_H, RUN_L} state_t;
    localparam logic [31:0] MIN_HALF  = 32'd64;
    localparam logic [31:0] ACQ_LEN   = 32'd32;
    localparam logic [31:0] MARGIN    = 32'd4;
    localparam logic [31:0] MAX_AVG   = 32'd5;
    localparam logic [31:0] WDT_LIMIT = 32'd8;
    localparam logic [31:0] RST_WAIT  = 32'd10;
    localparam logic [31:0] RST_AVG   = 32'd3;
endpackage

// File: rtl/mod_trig_scheduler_cfg_validate.sv
// mod_cfg_validate: rejects short half periods and clamps averaging shift and settle wait
module mod_cfg_validate
    import fog_sched_pkg::*;
(
    input  logic [31:0] half_req,
    input  logic [31:0] wait_req,
    input  logic [31:0] avg_req,
    input  logic [31:0] half_cur,
    output logic [31:0] half_out,
    output logic [31:0] wait_out,
    output logic [31:0] avg_out,
    output logic        clamp
);
    logic [31:0] lim;
    // the wait limit uses the half period that will actually be applied, so a reject keeps acquisition inside it
    always_comb begin
        half_out = half_req >= MIN_HALF ? half_req : half_cur;
        lim = half_out - ACQ_LEN - MARGIN;
        avg_out = avg_req > MAX_AVG ? MAX_AVG : avg_req;
        wait_out = wait_req > lim ? lim : wait_req;
        clamp = half_req < MIN_HALF || avg_req > MAX_AVG || wait_req > lim;
    end
endmodule

// File: rtl/mod_trig_scheduler.sv
// mod_trig_scheduler: square-wave modulation level and half-period trigger with period-aligned config.
// Optional step-sync watchdog enabled by defining MOD_TRIG_WDT_EN.
module mod_trig_scheduler
    import fog_sched_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic [31:0] i_half_cnt,
    input  logic [31:0] i_wait_cnt,
    input  logic [31:0] i_avg_sel,
    input  logic        i_step_sync,
    output logic        o_status,
    output logic        o_trig,
    output logic [31:0] o_wait_cnt,
    output logic [31:0] o_avg_sel,
    output logic        o_busy,
    output logic        o_cfg_clamp,
    output logic        o_fault
);
    state_t state, state_nxt;
    logic en_q;
    logic [31:0] half_q, wait_q, avg_q;
    logic [31:0] half_r, cnt;
    logic [31:0] v_half, v_wait, v_avg;
    logic v_clamp, half_end, status_nxt, fault_nxt;

    mod_cfg_validate u_validate (
        .half_req (half_q),
        .wait_req (wait_q),
        .avg_req  (avg_q),
        .half_cur (half_r),
        .half_out (v_half),
        .wait_out (v_wait),
        .avg_out  (v_avg),
        .clamp    (v_clamp)
    );

    assign half_end = cnt == half_r - 32'd1;
    assign o_busy = state == RUN_H || state == RUN_L;

    // one-cycle input register stage
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            en_q <= 1'b0;
            half_q <= '0;
            wait_q <= '0;
            avg_q <= '0;
        end else begin
            en_q <= i_en;
            half_q <= i_half_cnt;
            wait_q <= i_wait_cnt;
            avg_q <= i_avg_sel;
        end

    // state register
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) state <= IDLE;
        else state <= state_nxt;

    // next state; a period ending with en low drops to IDLE with status already low, so no trigger
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = en_q && !o_fault ? LOAD : IDLE;
            LOAD:    state_nxt = RUN_H;
            RUN_H:   state_nxt = half_end ? RUN_L : RUN_H;
            RUN_L:   state_nxt = !half_end ? RUN_L : en_q && !fault_nxt ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
        status_nxt = state_nxt == LOAD || state_nxt == RUN_H;
    end

    // LOAD is H-cycle 0 with the counter at 0; registered level, edge trigger and shadow config capture
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            cnt <= '0;
            half_r <= MIN_HALF;
            o_wait_cnt <= RST_WAIT;
            o_avg_sel <= RST_AVG;
            o_cfg_clamp <= 1'b0;
            o_status <= 1'b0;
            o_trig <= 1'b0;
        end else begin
            cnt <= state == IDLE || half_end ? '0 : cnt + 32'd1;
            o_status <= status_nxt;
            o_trig <= status_nxt ^ o_status;
            if (state == LOAD) begin
                half_r <= v_half;
                o_wait_cnt <= v_wait;
                o_avg_sel <= v_avg;
                o_cfg_clamp <= v_clamp;
            end
        end

`ifdef MOD_TRIG_WDT_EN
    logic sync_q, seen;
    logic [31:0] wdt_cnt, wdt_nxt;

    assign wdt_nxt = seen || sync_q ? '0 : wdt_cnt + 32'd1;
    assign fault_nxt = o_fault || (state == RUN_L && half_end && wdt_nxt >= WDT_LIMIT);

    // count whole periods without a step sync; the fault is sticky and blocks further loads
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            sync_q <= 1'b0;
            seen <= 1'b0;
            wdt_cnt <= '0;
            o_fault <= 1'b0;
        end else begin
            sync_q <= i_step_sync;
            o_fault <= fault_nxt;
            if (state == RUN_L && half_end) begin
                seen <= 1'b0;
                wdt_cnt <= wdt_nxt;
            end else begin
                seen <= state != IDLE && (seen || sync_q);
            end
        end
`else
    logic unused_step_sync;
    assign unused_step_sync = i_step_sync;
    assign fault_nxt = 1'b0;
    assign o_fault = 1'b0;
`endif
endmodule

// File: tb/tb_mod_trig_scheduler.sv
// tb_mod_trig_scheduler: randomized run against a period-level reference model with a trigger scoreboard
module tb_mod_trig_scheduler;
    localparam int NCYC = 20000;

    logic i_clk = 1'b0, i_rst_n = 1'b0, i_en = 1'b0, i_step_sync = 1'b0;
    logic [31:0] i_half_cnt = '0, i_wait_cnt = '0, i_avg_sel = '0;
    logic o_status, o_trig, o_busy, o_cfg_clamp, o_fault;
    logic [31:0] o_wait_cnt, o_avg_sel;

    typedef struct { int cyc; logic st; } ev_t;
    ev_t exp_q[$];
    logic exp_st[NCYC], exp_busy[NCYC], exp_cl[NCYC];
    logic [31:0] exp_w[NCYC], exp_a[NCYC];
    int vectors = 0, errors = 0;
    bit mon_done = 0;

    mod_trig_scheduler dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_en        (i_en),
        .i_half_cnt  (i_half_cnt),
        .i_wait_cnt  (i_wait_cnt),
        .i_avg_sel   (i_avg_sel),
        .i_step_sync (i_step_sync),
        .o_status    (o_status),
        .o_trig      (o_trig),
        .o_wait_cnt  (o_wait_cnt),
        .o_avg_sel   (o_avg_sel),
        .o_busy      (o_busy),
        .o_cfg_clamp (o_cfg_clamp),
        .o_fault     (o_fault)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // stimulus plus reference model: each period is derived from the inputs seen just before its LOAD
    initial begin
        logic [31:0] half_tab[8] = '{32'd40, 32'd63, 32'd64, 32'd65, 32'd100, 32'd200, 32'd128, 32'd150};
        logic [31:0] wait_tab[8] = '{32'd0, 32'd10, 32'd20, 32'd28, 32'd29, 32'd50, 32'hFFFF_FFFF, 32'd100};
        logic [31:0] avg_tab[8]  = '{32'd0, 32'd3, 32'd5, 32'd6, 32'd9, 32'h8000_0000, 32'd4, 32'd1};
        logic [31:0] m_half, half, wt, avg, w, a, lim;
        logic en, cl;
        int lc, h, nl, idle_from, idx;
        bit run, found;
        for (int k = 0; k < NCYC; k++) begin
            exp_st[k] = 1'b0;
            exp_busy[k] = 1'b0;
            exp_cl[k] = 1'b0;
            exp_w[k] = 32'd10;
            exp_a[k] = 32'd3;
        end
        m_half = 32'd64;
        half = 32'd100;
        wt = 32'd20;
        avg = 32'd5;
        en = 1'b1;
        lc = 0;
        h = 0;
        nl = -1;
        idle_from = 0;
        run = 0;
        found = 0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("reset_outputs", {o_status, o_busy, o_cfg_clamp, o_fault, o_wait_cnt, o_avg_sel}, {4'b0000, 32'd10, 32'd3});
        check("reset_trig", 68'(o_trig), 68'd0);
        i_rst_n = 1'b1;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge i_clk);
            #1;
            if (c > 0) begin
                if ($urandom_range(0, 299) == 0) en = !en;
                if ($urandom_range(0, 149) == 0) begin
                    idx = int'($urandom_range(0, 7));
                    half = $urandom_range(0, 3) == 0 ? 32'($urandom_range(64, 160)) : half_tab[idx];
                    idx = int'($urandom_range(0, 7));
                    wt = wait_tab[idx];
                    idx = int'($urandom_range(0, 7));
                    avg = avg_tab[idx];
                end
            end
            i_en = en;
            i_half_cnt = half;
            i_wait_cnt = wt;
            i_avg_sel = avg;
            i_step_sync = $urandom_range(0, 15) == 0;
            if (run && c == lc + 2 * h - 2) begin
                run = 0;
                if (en) nl = lc + 2 * h;
                else idle_from = lc + 2 * h;
            end else if (!run && nl < 0 && c >= idle_from - 1 && en) begin
                nl = c + 2;
            end
            if (c == nl - 1) begin
                cl = 1'b0;
                if (half >= 32'd64) m_half = half;
                else cl = 1'b1;
                a = avg;
                if (a > 32'd5) begin
                    a = 32'd5;
                    cl = 1'b1;
                end
                lim = m_half - 32'd36;
                w = wt;
                if (w > lim) begin
                    w = lim;
                    cl = 1'b1;
                end
                lc = nl;
                nl = -1;
                run = 1;
                h = int'(m_half);
                for (int k = lc; k < lc + 2 * h && k < NCYC; k++) begin
                    exp_st[k] = k < lc + h;
                    exp_busy[k] = k != lc;
                end
                for (int k = lc + 1; k < NCYC; k++) begin
                    exp_w[k] = w;
                    exp_a[k] = a;
                    exp_cl[k] = cl;
                end
                exp_q.push_back(ev_t'{lc, 1'b1});
                exp_q.push_back(ev_t'{lc + h, 1'b0});
            end
        end
        wait (mon_done);
        i_en = 1'b1;
        i_half_cnt = 32'd100;
        i_wait_cnt = 32'd20;
        i_avg_sel = 32'd5;
        for (int k = 0; k < 2000 && !found; k++) begin
            @(negedge i_clk);
            found = o_busy && !o_status && o_wait_cnt == 32'd20;
        end
        check("reach_run_l", 68'(found), 68'd1);
        repeat (10) @(negedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("async_reset", {o_status, o_busy, o_cfg_clamp, o_fault, o_wait_cnt, o_avg_sel}, {4'b0000, 32'd10, 32'd3});
        check("async_reset_trig", 68'(o_trig), 68'd0);
        @(negedge i_clk);
        check("reset_held", {o_status, o_trig, o_busy, o_wait_cnt}, {3'b000, 33'd0, 32'd10});
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // monitor: per-cycle levels against the model arrays, triggers popped from the scoreboard
    initial begin
        ev_t e;
        @(posedge i_rst_n);
        for (int c = 0; c < NCYC; c++) begin
            @(negedge i_clk);
            check("cycle_outputs", {o_status, o_busy, o_cfg_clamp, o_fault, o_wait_cnt, o_avg_sel},
                  {exp_st[c], exp_busy[c], exp_cl[c], 1'b0, exp_w[c], exp_a[c]});
            while (exp_q.size() > 0 && exp_q[0].cyc < c) begin
                vectors++;
                errors++;
                $display("FAIL trig_missing: no trig seen, required at cycle %0d", exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (o_trig) begin
                if (exp_q.size() == 0 || exp_q[0].cyc != c) begin
                    vectors++;
                    errors++;
                    $display("FAIL trig_unexpected: trig at cycle %0d, required none", c);
                end else begin
                    e = exp_q.pop_front();
                    check("trig_level", 68'(o_status), 68'(e.st));
                end
            end
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < NCYC) begin
            vectors++;
            errors++;
            $display("FAIL trig_missing: no trig seen, required at cycle %0d", exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        mon_done = 1;
    end
endmodule
